// File: rtl/mem_boot_arbiter.sv
// Unified memory port arbiter and BOOT/RUN sequencer for a multi-cycle MIPS32 core.
// The core always wins the memory in RUN; the loader only gets idle cycles there.
module mem_boot_arbiter #(
  parameter int unsigned WDT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic        halt,
  output logic        core_nrst,
  input  logic        core_mem_read,
  input  logic        core_mem_write,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic [31:0] ld_rdata,
  output logic        ld_rvalid,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        running,
  output logic [31:0] run_cycles,
  output logic        wdt_expired
);
  localparam logic [0:0]  BOOT     = 1'b0;
  localparam logic [0:0]  RUN      = 1'b1;
  localparam logic        WDT_ON   = (WDT_CYCLES != 0);
  localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);

  logic [0:0] state;
  logic       core_busy;
  logic       ld_read;
  logic       wdt_fire;

  assign running    = (state == RUN);
  assign core_busy  = running & (core_mem_read | core_mem_write);
  assign core_rdata = mem_rdata;
  assign ld_gnt     = ld_req & ~core_busy;
  assign ld_read    = ld_gnt & ~ld_we;
  assign wdt_fire   = running & WDT_ON & (run_cycles == WDT_LAST);

  // With no access pending the loader inputs still drive the bus, strobes low.
  always_comb begin
    if (core_busy) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = core_mem_write;
      mem_re    = core_mem_read & ~core_mem_write;
    end else begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_we    = ld_req & ld_we;
      mem_re    = ld_req & ~ld_we;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= BOOT;
      core_nrst   <= 1'b0;
      run_cycles  <= '0;
      wdt_expired <= 1'b0;
      ld_rvalid   <= 1'b0;
      ld_rdata    <= '0;
    end else begin
      ld_rvalid <= ld_read;
      if (ld_read) ld_rdata <= mem_rdata;
      case (state)
        BOOT: begin
          if (start) begin
            state       <= RUN;
            run_cycles  <= '0;
            wdt_expired <= 1'b0;
            core_nrst   <= 1'b1;
          end
        end
        default: begin
          // The expiry edge still counts, so run_cycles reads back WDT_CYCLES.
          if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
          if (wdt_fire || halt) begin
            state     <= BOOT;
            core_nrst <= 1'b0;
          end
          if (wdt_fire) wdt_expired <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_boot_arbiter.md
# mem_boot_arbiter

Owns the single unified memory port and sequences the multi-cycle MIPS32 core's life cycle. In BOOT it holds the core in reset and gives the memory to an external program loader. In RUN it releases the core, gives the core absolute memory priority, and lets the loader use only idle memory cycles. A run-cycle counter with an optional watchdog returns the system to BOOT.

## Interface
- WDT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; in BOOT, enter RUN
- halt  in  1  one-cycle pulse; in RUN, return to BOOT
- core_nrst  out  1  registered reset to core, low = core held in reset
- core_mem_read  in  1  core read request (MemRead)
- core_mem_write  in  1  core write request (MemWrite)
- core_addr  in  32  core address
- core_wdata  in  32  core write data
- core_rdata  out  32  read data to core, = mem_rdata
- ld_req  in  1  loader access request, level
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  32  loader address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  combinational grant; access performed this cycle
- ld_rdata  out  32  registered loader read data
- ld_rvalid  out  1  ld_rdata valid, one-cycle pulse
- mem_re, mem_we  out  1 each  memory strobes
- mem_addr, mem_wdata  out  32 each  memory address and write data
- mem_rdata  in  32  memory data; combinational read, synchronous write
- running  out  1  state == RUN
- run_cycles  out  32  RUN cycle count
- wdt_expired  out  1  sticky watchdog flag

## Operation
- States: BOOT, RUN. Reset enters BOOT.
- Output reset values: core_nrst 0, ld_rvalid 0, ld_rdata 0, run_cycles 0, wdt_expired 0, running 0.
- Reset values of combinational outputs follow from the BOOT mux below.
- BOOT:
  - Loader owns memory: mem_addr = ld_addr, mem_wdata = ld_wdata, mem_we = ld_req&ld_we, mem_re = ld_req&~ld_we.
  - ld_gnt = ld_req.
  - Core inputs are ignored.
- RUN, core busy (core_mem_read | core_mem_write):
  - mem_addr = core_addr, mem_wdata = core_wdata.
  - If both core strobes are high, the write wins: mem_we = 1, mem_re = 0.
  - ld_gnt = 0.
- RUN, core idle: the loader mux from BOOT applies; ld_gnt = ld_req.
- No access in progress: mem_re = mem_we = 0; mem_addr and mem_wdata follow the loader inputs.
- Granted loader read: ld_rdata <= mem_rdata and ld_rvalid <= 1 at the next edge; otherwise ld_rvalid <= 0 and ld_rdata holds.
- BOOT to RUN on start: run_cycles <= 0, wdt_expired <= 0, core_nrst <= 1.
- RUN to BOOT on halt: core_nrst <= 0. run_cycles holds its value for readout.
- run_cycles increments on every RUN edge and saturates at 32'hFFFFFFFF.
- Watchdog: fires when WDT_CYCLES != 0 and run_cycles == WDT_CYCLES-1 at an edge in RUN.
  - Next state is BOOT, wdt_expired <= 1, core_nrst <= 0.
  - run_cycles still increments on that edge.
- Priorities and ignored inputs:
  - start is ignored in RUN; halt is ignored in BOOT.
  - In RUN, halt and the watchdog together: both outcomes are identical, and wdt_expired is set.

## Timing
- Grant and memory mux are combinational, zero latency. Loader read data arrives 1 cycle after grant.
- core_nrst rises on the edge that samples start and falls on the edge that samples halt or watchdog expiry.
- Core memory cycles within that RUN window are unaffected.
- start sampled together with ld_req in BOOT: the loader access completes in that cycle, then RUN begins.
- A loader read granted on the last RUN cycle still returns ld_rvalid on the following cycle.
- Asynchronous reset mid-operation: immediate BOOT, core_nrst 0, ld_rvalid 0, counters cleared. An in-flight loader read is dropped.
- With WDT_CYCLES = N, core_nrst stays high for exactly N cycles.

## Test plan
- Reset, then in BOOT write 0x8C010004 to 0x0 via the loader and read it back. Expect ld_gnt = 1 during both accesses, and ld_rvalid one cycle after the read with ld_rdata = 0x8C010004. core_nrst stays 0 throughout.
- Start, then in RUN hold ld_req with a read while core_mem_read = 1 for 3 cycles, then idle. Expect ld_gnt = 0 for 3 cycles, mem_addr = core_addr, then a grant on the 4th cycle and ld_rvalid on the 5th.
- In RUN drive core_mem_read = core_mem_write = 1 with core_addr 0x10 and core_wdata 0xDEADBEEF. Expect mem_we = 1, mem_re = 0, and the word written.
- WDT_CYCLES = 5, start. Expect core_nrst high for exactly 5 cycles, then running = 0, wdt_expired = 1, run_cycles = 5. A second start clears wdt_expired and run_cycles.
- Assert halt and start together in RUN. Expect a return to BOOT. Then assert halt alone in BOOT and expect no change.
- Assert nrst low mid-RUN during a granted loader read. Expect immediate core_nrst = 0, ld_rvalid = 0 and run_cycles = 0.
